// File: rtl/sprite_commit_pkg.sv
// Shared types and widths for the vblank-synchronous sprite commit controller.
package sprite_commit_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic SEL_POS = 1'b0;
   localparam logic SEL_ATT = 1'b1;

   localparam int DEF_NUM_SPRITES = 8;
   localparam int X_W             = 10;
   localparam int Y_W             = 9;

endpackage

// File: rtl/sprite_shadow_regs.sv
// Per-sprite shadow copies of position/attribute writes plus dirty flags,
// with a host write port, one indexed read port and per-phase dirty clears.
module sprite_shadow_regs
   import sprite_commit_pkg::*;
#(
   parameter int NUM_SPRITES = DEF_NUM_SPRITES,
   parameter int IDX_W       = 3
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic             i_wr_sel,
   input  logic [X_W-1:0]   i_wr_x,
   input  logic [Y_W-1:0]   i_wr_y,
   input  logic             i_wr_vis,
   input  logic [IDX_W-1:0] i_rd_idx,
   input  logic             i_clr_pos,
   input  logic             i_clr_att,
   output logic             o_wr_hit,
   output logic             o_any_dirty,
   output logic [X_W-1:0]   o_pos_x,
   output logic [Y_W-1:0]   o_pos_y,
   output logic             o_att_x0,
   output logic             o_att_y0,
   output logic             o_att_vis,
   output logic             o_dirty_pos,
   output logic             o_dirty_att
);

   logic [X_W-1:0]         r_pos_x [NUM_SPRITES];
   logic [Y_W-1:0]         r_pos_y [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] r_att_x0;
   logic [NUM_SPRITES-1:0] r_att_y0;
   logic [NUM_SPRITES-1:0] r_att_vis;
   logic [NUM_SPRITES-1:0] r_dirty_pos;
   logic [NUM_SPRITES-1:0] r_dirty_att;
   logic [NUM_SPRITES-1:0] w_wr_hit;

   // Decoding by slot keeps out-of-range indices from touching any entry.
   always_comb begin
      w_wr_hit = '0;
      for (int i = 0; i < NUM_SPRITES; i++)
         w_wr_hit[i] = i_wr_en && (i_wr_idx == IDX_W'(i));
   end

   assign o_wr_hit    = |w_wr_hit;
   assign o_any_dirty = |{r_dirty_pos, r_dirty_att};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_pos_x[i] <= '0;
            r_pos_y[i] <= '0;
         end
         r_att_x0    <= '0;
         r_att_y0    <= '0;
         r_att_vis   <= '0;
         r_dirty_pos <= '0;
         r_dirty_att <= '0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (w_wr_hit[i] && (i_wr_sel == SEL_POS)) begin
               r_pos_x[i]     <= i_wr_x;
               r_pos_y[i]     <= i_wr_y;
               r_dirty_pos[i] <= 1'b1;
            end else if (w_wr_hit[i] && (i_wr_sel == SEL_ATT)) begin
               r_att_x0[i]    <= i_wr_x[0];
               r_att_y0[i]    <= i_wr_y[0];
               r_att_vis[i]   <= i_wr_vis;
               r_dirty_att[i] <= 1'b1;
            end
            if (i_clr_pos && (i_rd_idx == IDX_W'(i)))
               r_dirty_pos[i] <= 1'b0;
            if (i_clr_att && (i_rd_idx == IDX_W'(i)))
               r_dirty_att[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      o_pos_x     = '0;
      o_pos_y     = '0;
      o_att_x0    = 1'b0;
      o_att_y0    = 1'b0;
      o_att_vis   = 1'b0;
      o_dirty_pos = 1'b0;
      o_dirty_att = 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (i_rd_idx == IDX_W'(i)) begin
            o_pos_x     = r_pos_x[i];
            o_pos_y     = r_pos_y[i];
            o_att_x0    = r_att_x0[i];
            o_att_y0    = r_att_y0[i];
            o_att_vis   = r_att_vis[i];
            o_dirty_pos = r_dirty_pos[i];
            o_dirty_att = r_dirty_att[i];
         end
      end
   end

endmodule

// File: rtl/sprite_commit_ctrl.sv
// Commits buffered sprite writes during vblank: one scan step per cycle,
// position then attribute per slot, one registered load strobe per step.
module sprite_commit_ctrl
   import sprite_commit_pkg::*;
#(
   parameter int NUM_SPRITES = DEF_NUM_SPRITES,
   parameter int IDX_W       = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   vblank,
   input  logic                   wr_en,
   input  logic [IDX_W-1:0]       wr_idx,
   input  logic                   wr_sel,
   input  logic [X_W-1:0]         wr_x,
   input  logic [Y_W-1:0]         wr_y,
   input  logic                   wr_vis,
   output logic                   wr_ready,
   output logic [X_W-1:0]         spr_x,
   output logic [Y_W-1:0]         spr_y,
   output logic                   spr_visible,
   output logic [NUM_SPRITES-1:0] load_pos,
   output logic [NUM_SPRITES-1:0] load_att,
   output logic                   busy,
   output logic                   commit_done
);

   localparam int                STEP_W    = IDX_W + 2;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * NUM_SPRITES);

   state_t                 r_state, w_state_nxt;
   logic [STEP_W-1:0]      r_step, w_step_nxt;
   logic                   r_vblank_q;
   logic                   w_rise, w_wr_acc, w_wr_hit, w_any_dirty;
   logic                   w_exec, w_done;
   logic [IDX_W-1:0]       w_slot;
   logic                   w_att_phase;
   logic [X_W-1:0]         w_rd_pos_x;
   logic [Y_W-1:0]         w_rd_pos_y;
   logic                   w_rd_att_x0, w_rd_att_y0, w_rd_att_vis;
   logic                   w_rd_dirty_pos, w_rd_dirty_att;
   logic                   w_clr_pos, w_clr_att;
   logic [NUM_SPRITES-1:0] w_load_pos_nxt, w_load_att_nxt;
   logic [X_W-1:0]         w_spr_x_nxt;
   logic [Y_W-1:0]         w_spr_y_nxt;
   logic                   w_spr_vis_nxt;

   assign busy        = (r_state == SCAN);
   assign wr_ready    = ~busy;
   assign w_wr_acc    = wr_en & wr_ready;
   assign w_rise      = vblank & ~r_vblank_q;
   assign w_slot      = r_step[IDX_W:1];
   assign w_att_phase = r_step[0];

   sprite_shadow_regs #(
      .NUM_SPRITES (NUM_SPRITES),
      .IDX_W       (IDX_W)
   ) u_shadow (
      .i_clk       (clk),
      .i_rst_n     (rst),
      .i_wr_en     (w_wr_acc),
      .i_wr_idx    (wr_idx),
      .i_wr_sel    (wr_sel),
      .i_wr_x      (wr_x),
      .i_wr_y      (wr_y),
      .i_wr_vis    (wr_vis),
      .i_rd_idx    (w_slot),
      .i_clr_pos   (w_clr_pos),
      .i_clr_att   (w_clr_att),
      .o_wr_hit    (w_wr_hit),
      .o_any_dirty (w_any_dirty),
      .o_pos_x     (w_rd_pos_x),
      .o_pos_y     (w_rd_pos_y),
      .o_att_x0    (w_rd_att_x0),
      .o_att_y0    (w_rd_att_y0),
      .o_att_vis   (w_rd_att_vis),
      .o_dirty_pos (w_rd_dirty_pos),
      .o_dirty_att (w_rd_dirty_att)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_step     <= '0;
         r_vblank_q <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_step     <= w_step_nxt;
         r_vblank_q <= vblank;
      end
   end

   // A write landing on the vblank rising edge counts as pending for entry.
   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_exec      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise && (w_any_dirty || w_wr_hit)) begin
               w_state_nxt = SCAN;
               w_step_nxt  = '0;
            end
         end
         SCAN: begin
            if (!vblank) begin
               w_state_nxt = IDLE;
            end else if (r_step == LAST_STEP) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
            end else begin
               w_exec     = 1'b1;
               w_step_nxt = r_step + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_load_pos_nxt = '0;
      w_load_att_nxt = '0;
      w_spr_x_nxt    = spr_x;
      w_spr_y_nxt    = spr_y;
      w_spr_vis_nxt  = spr_visible;
      w_clr_pos      = 1'b0;
      w_clr_att      = 1'b0;
      if (w_exec && !w_att_phase && w_rd_dirty_pos) begin
         w_load_pos_nxt = NUM_SPRITES'(1) << w_slot;
         w_spr_x_nxt    = w_rd_pos_x;
         w_spr_y_nxt    = w_rd_pos_y;
         w_spr_vis_nxt  = w_rd_att_vis;
         w_clr_pos      = 1'b1;
      end else if (w_exec && w_att_phase && w_rd_dirty_att) begin
         w_load_att_nxt = NUM_SPRITES'(1) << w_slot;
         w_spr_x_nxt    = {{(X_W-1){1'b0}}, w_rd_att_x0};
         w_spr_y_nxt    = {{(Y_W-1){1'b0}}, w_rd_att_y0};
         w_spr_vis_nxt  = w_rd_att_vis;
         w_clr_att      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_pos    <= '0;
         load_att    <= '0;
         spr_x       <= '0;
         spr_y       <= '0;
         spr_visible <= 1'b0;
         commit_done <= 1'b0;
      end else begin
         load_pos    <= w_load_pos_nxt;
         load_att    <= w_load_att_nxt;
         spr_x       <= w_spr_x_nxt;
         spr_y       <= w_spr_y_nxt;
         spr_visible <= w_spr_vis_nxt;
         commit_done <= w_done;
      end
   end

endmodule

// File: tb/tb_sprite_commit_ctrl.sv
// Scenario bench for sprite_commit_ctrl: shadow-table reference model and an
// expected-strobe queue built from the dirty table at each commit.
module tb_sprite_commit_ctrl;

   localparam int NS        = 8;
   localparam int IW        = 3;
   localparam int LAST_EDGE = 2 * NS + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          vblank;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic          wr_sel;
   logic [9:0]    wr_x;
   logic [8:0]    wr_y;
   logic          wr_vis;
   logic          wr_ready;
   logic [9:0]    spr_x;
   logic [8:0]    spr_y;
   logic          spr_visible;
   logic [NS-1:0] load_pos;
   logic [NS-1:0] load_att;
   logic          busy;
   logic          commit_done;

   int errors = 0;
   int checks = 0;

   // Reference model: shadow table, dirty flags and the shared bus value.
   logic [9:0] m_pos_x [NS];
   logic [8:0] m_pos_y [NS];
   logic       m_att_x0 [NS];
   logic       m_att_y0 [NS];
   logic       m_att_vis [NS];
   logic       m_dp [NS];
   logic       m_da [NS];
   logic [9:0] m_bx;
   logic [8:0] m_by;
   logic       m_bv;

   typedef struct {
      int         cyc;
      bit         is_pos;
      int         slot;
      logic [9:0] x;
      logic [8:0] y;
      logic       vis;
   } ev_t;
   ev_t exp_q[$];

   logic [IW-1:0] h_idx;
   logic          h_sel;
   logic [9:0]    h_x;
   logic [8:0]    h_y;
   logic          h_vis;

   sprite_commit_ctrl #(.NUM_SPRITES(NS), .IDX_W(IW)) dut (
      .clk         (clk),
      .rst         (rst),
      .vblank      (vblank),
      .wr_en       (wr_en),
      .wr_idx      (wr_idx),
      .wr_sel      (wr_sel),
      .wr_x        (wr_x),
      .wr_y        (wr_y),
      .wr_vis      (wr_vis),
      .wr_ready    (wr_ready),
      .spr_x       (spr_x),
      .spr_y       (spr_y),
      .spr_visible (spr_visible),
      .load_pos    (load_pos),
      .load_att    (load_att),
      .busy        (busy),
      .commit_done (commit_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NS; i++) begin
         m_pos_x[i] = '0; m_pos_y[i] = '0;
         m_att_x0[i] = 1'b0; m_att_y0[i] = 1'b0; m_att_vis[i] = 1'b0;
         m_dp[i] = 1'b0; m_da[i] = 1'b0;
      end
      m_bx = '0; m_by = '0; m_bv = 1'b0;
   endfunction

   function automatic void model_write(int idx, logic sel, logic [9:0] x, logic [8:0] y, logic vis);
      if (idx >= NS) return;
      if (sel == 1'b0) begin
         m_pos_x[idx] = x; m_pos_y[idx] = y; m_dp[idx] = 1'b1;
      end else begin
         m_att_x0[idx] = x[0]; m_att_y0[idx] = y[0]; m_att_vis[idx] = vis; m_da[idx] = 1'b1;
      end
   endfunction

   task automatic do_write(input int idx, input logic sel, input logic [9:0] x,
                           input logic [8:0] y, input logic vis);
      wr_en = 1'b1; wr_idx = IW'(idx); wr_sel = sel; wr_x = x; wr_y = y; wr_vis = vis;
      for (int t = 0; t < 100 && !wr_ready; t++) tick();
      checks++;
      if (wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL write_accept: got wr_ready=%b expected 1", wr_ready);
      end
      model_write(idx, sel, x, y, vis);
      tick();
      wr_en = 1'b0;
   endtask

   // Raise vblank and follow the whole commit edge by edge. abort_at = edge
   // index whose preceding vblank is dropped (0 = no abort).
   task automatic run_commit(input int abort_at, input bit hold_wr);
      bit            started;
      bit            stop;
      ev_t           ev;
      logic [NS-1:0] e_pos, e_att;
      logic [2:0]    e_ctl;
      if (wr_en) model_write(int'(wr_idx), wr_sel, wr_x, wr_y, wr_vis);
      vblank = 1'b1;
      tick();
      wr_en = 1'b0;
      started = 1'b0;
      for (int i = 0; i < NS; i++) if (m_dp[i] || m_da[i]) started = 1'b1;
      checks++;
      if (busy !== started) begin
         errors++;
         $display("FAIL scan_entry: got busy=%b expected %b", busy, started);
      end
      exp_q.delete();
      for (int i = 0; i < NS; i++) begin
         if (m_dp[i]) exp_q.push_back('{2*i+1, 1'b1, i, m_pos_x[i], m_pos_y[i], m_att_vis[i]});
         if (m_da[i]) exp_q.push_back('{2*i+2, 1'b0, i, {9'b0, m_att_x0[i]}, {8'b0, m_att_y0[i]}, m_att_vis[i]});
      end
      if (started && hold_wr) begin
         wr_en = 1'b1; wr_idx = h_idx; wr_sel = h_sel; wr_x = h_x; wr_y = h_y; wr_vis = h_vis;
      end
      stop = !started;
      for (int k = 1; k <= LAST_EDGE && !stop; k++) begin
         if (k == abort_at) vblank = 1'b0;
         tick();
         e_pos = '0; e_att = '0;
         if (k == abort_at) begin
            e_ctl = 3'b010;
            stop  = 1'b1;
         end else begin
            e_ctl = (k == LAST_EDGE) ? 3'b011 : 3'b100;
            if (exp_q.size() > 0 && exp_q[0].cyc == k) begin
               ev = exp_q.pop_front();
               if (ev.is_pos) begin e_pos[ev.slot] = 1'b1; m_dp[ev.slot] = 1'b0; end
               else begin e_att[ev.slot] = 1'b1; m_da[ev.slot] = 1'b0; end
               m_bx = ev.x; m_by = ev.y; m_bv = ev.vis;
            end
         end
         checks++;
         if ({load_pos, load_att} !== {e_pos, e_att}) begin
            errors++;
            $display("FAIL strobe edge %0d: got pos=%h att=%h expected pos=%h att=%h",
                     k, load_pos, load_att, e_pos, e_att);
         end
         checks++;
         if ({spr_x, spr_y, spr_visible} !== {m_bx, m_by, m_bv}) begin
            errors++;
            $display("FAIL bus edge %0d: got x=%0d y=%0d v=%b expected x=%0d y=%0d v=%b",
                     k, spr_x, spr_y, spr_visible, m_bx, m_by, m_bv);
         end
         checks++;
         if ({busy, wr_ready, commit_done} !== e_ctl) begin
            errors++;
            $display("FAIL control edge %0d: got busy/ready/done=%b expected %b",
                     k, {busy, wr_ready, commit_done}, e_ctl);
         end
      end
      vblank = 1'b0;
      if (wr_en) model_write(int'(wr_idx), wr_sel, wr_x, wr_y, wr_vis);
      tick();
      wr_en = 1'b0;
      checks++;
      if ({load_pos, load_att, commit_done, busy} !== '0) begin
         errors++;
         $display("FAIL post_commit: got pos=%h att=%h done=%b busy=%b expected all 0",
                  load_pos, load_att, commit_done, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; vblank = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_sel = 1'b0;
      wr_x = '0; wr_y = '0; wr_vis = 1'b0;
      model_reset();
      #13;
      checks++;
      if ({load_pos, load_att, spr_x, spr_y, spr_visible, busy, commit_done, wr_ready} !== {{(2*NS+22){1'b0}}, 1'b1}) begin
         errors++;
         $display("FAIL reset_values: got pos=%h att=%h x=%0d y=%0d v=%b busy=%b done=%b ready=%b expected zeros ready=1",
                  load_pos, load_att, spr_x, spr_y, spr_visible, busy, commit_done, wr_ready);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_idle_vblank();
      for (int c = 0; c < 40; c++) begin
         vblank = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if ({load_pos, load_att, busy, wr_ready, commit_done} !== {{(2*NS){1'b0}}, 3'b010}) begin
            errors++;
            $display("FAIL idle_quiet cycle %0d: got pos=%h att=%h busy/ready/done=%b expected 0 0 010",
                     c, load_pos, load_att, {busy, wr_ready, commit_done});
         end
      end
      vblank = 1'b0;
      tick();
   endtask

   task automatic test_pos_slot3();
      do_write(3, 1'b0, 10'd200, 9'd101, 1'b0);
      run_commit(0, 1'b0);
      run_commit(0, 1'b0);
   endtask

   task automatic test_att_and_pos();
      do_write(0, 1'b1, 10'd1, 9'd0, 1'b1);
      do_write(7, 1'b0, 10'($urandom), 9'($urandom), 1'b0);
      run_commit(0, 1'b0);
   endtask

   task automatic test_overwrite();
      do_write(2, 1'b0, 10'd5, 9'd33, 1'b0);
      do_write(2, 1'b0, 10'd9, 9'd44, 1'b0);
      run_commit(0, 1'b0);
   endtask

   task automatic test_abort();
      for (int i = 0; i < NS; i++) begin
         do_write(i, 1'b0, 10'($urandom), 9'($urandom), 1'b0);
         do_write(i, 1'b1, 10'($urandom), 9'($urandom), 1'($urandom));
      end
      run_commit(6, 1'b0);
      run_commit(0, 1'b0);
   endtask

   task automatic test_same_edge_write();
      wr_en = 1'b1; wr_idx = 3'd5; wr_sel = 1'b0; wr_x = 10'd777; wr_y = 9'd300; wr_vis = 1'b0;
      run_commit(0, 1'b0);
   endtask

   task automatic test_write_blocked();
      do_write(6, 1'b0, 10'd111, 9'd222, 1'b0);
      h_idx = 3'd6; h_sel = 1'b0; h_x = 10'd999; h_y = 9'd444; h_vis = 1'b0;
      run_commit(0, 1'b1);
      run_commit(0, 1'b0);
   endtask

   task automatic test_async_reset();
      do_write(1, 1'b0, 10'd50, 9'd60, 1'b0);
      do_write(1, 1'b1, 10'd1, 9'd1, 1'b1);
      do_write(4, 1'b0, 10'd70, 9'd80, 1'b0);
      vblank = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({load_pos, load_att, spr_x, spr_y, spr_visible, busy, commit_done, wr_ready} !== {{(2*NS+22){1'b0}}, 1'b1}) begin
         errors++;
         $display("FAIL async_reset: got pos=%h att=%h x=%0d y=%0d v=%b busy=%b done=%b ready=%b expected zeros ready=1",
                  load_pos, load_att, spr_x, spr_y, spr_visible, busy, commit_done, wr_ready);
      end
      vblank = 1'b0;
      model_reset();
      #2;
      rst = 1'b1;
      tick();
      run_commit(0, 1'b0);
   endtask

   task automatic test_random();
      int n;
      int ab;
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(0, 10);
         for (int w = 0; w < n; w++)
            do_write($urandom_range(0, NS-1), 1'($urandom), 10'($urandom), 9'($urandom), 1'($urandom));
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAST_EDGE) : 0;
         run_commit(ab, 1'b0);
      end
      run_commit(0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_idle_vblank();
      test_pos_slot3();
      test_att_and_pos();
      test_overwrite();
      test_abort();
      test_same_edge_write();
      test_write_blocked();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
